prime_lane_scheduler: RTL and testbench
=======================================

Name: prime_lane_scheduler

Overview:
- Sequences the parallel trial-division lanes of the multi-lane prime finder.
- Takes a test number and hands candidate divisors to up to NUM_LANES divisibility lanes, which have variable latency. It collects their verdicts and advances the candidate until a prime is found.
- Reports the original value, the first prime at or above it, and a prime flag for the original value.
- Sits between the top-level key/switch logic and the lane array, and drives the state, count and LED status outputs.

Parameters:
- NUM_LANES, 8, number of divisibility lanes scheduled (1..16).
- WIDTH, 32, bit width of test number, candidate and divisors.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level or pulse; sampled only in IDLE or DONE.
- test_number  in  WIDTH  value to test; captured on accepted start.
- lane_start  out  NUM_LANES  one-cycle issue pulse per lane.
- lane_dividend  out  WIDTH  current candidate, shared by all lanes.
- lane_divisor  out  NUM_LANES*WIDTH  per-lane divisor, held from issue until that lane's done.
- lane_done  in  NUM_LANES  one-cycle result pulse per lane.
- lane_divisible  in  NUM_LANES  qualified by lane_done: 1 means the divisor divides the dividend.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  level; high in DONE until the next accepted start.
- is_prime  out  1  valid when done: orig_val is prime.
- orig_val  out  WIDTH  captured test_number.
- prime_val  out  WIDTH  first prime >= orig_val; valid when done and overflow=0.
- count  out  WIDTH  candidate currently under test.
- overflow  out  1  candidate wrapped without finding a prime.
- state  out  3  encoded FSM state.

Behaviour:
- Reset: all outputs 0 and state = IDLE. Lane busy mask, found flag, divisor and square registers are cleared. A reset mid-run aborts immediately and no lane_start is issued after it; late lane_done pulses in IDLE are ignored.
- State encoding: IDLE=0, LOAD=1, DISPATCH=2, DRAIN=3, NEXT=4, DONE=5.
- IDLE/DONE + start -> LOAD. In that cycle orig_val and count take test_number, done clears, and overflow clears.
- LOAD (1 cycle):
  - If count < 2, count becomes 2.
  - Divisor d becomes 2 and its square sq becomes 4. sq is tracked incrementally at 2*WIDTH bits (sq += 2d+1 on each d++); no multiplier is used.
  - Next state is DISPATCH.
- DISPATCH, each cycle:
  - If sq <= count and found=0 and any lane is idle: issue d to the lowest-index idle lane (lane_start pulse, divisor latched, busy bit set), then d++ and sq update.
  - At most one issue per cycle.
  - A lane whose lane_done arrives this cycle is not reissued until the next cycle.
- Results:
  - A lane_done on a busy lane clears its busy bit.
  - If lane_divisible is set, found is set. A divisible result arriving after found is already set has no further effect.
  - lane_done on a non-busy lane is ignored.
- DISPATCH -> DRAIN when found=1, or when sq > count and no issue occurs this cycle. This covers candidates 2 and 3, which go to DRAIN with zero issues.
- DRAIN: wait until the busy mask is 0, counting done pulses in the same cycle.
  - found=1 -> NEXT.
  - found=0 -> DONE, with prime_val = count and is_prime = (count == orig_val).
- NEXT (1 cycle):
  - If count is all-ones: overflow=1, is_prime=0, prime_val=0, go to DONE.
  - Otherwise count++, found clears, d=2, sq=4, go to DISPATCH.
- start while busy is ignored. test_number changes after capture have no effect.
- Lane result timing: any latency of 1 cycle or more is legal; results may return out of order.

Decomposition:
- Shared package prime_pkg:
  - state encoding constants (IDLE..DONE);
  - default NUM_LANES and WIDTH;
  - a lowest-set-bit priority function, also reused by the top-level.
- One sub-module, prime_lane_alloc: an idle-lane priority picker that turns the busy mask into a one-hot grant plus a valid flag.

Test Plan:
- test_number=1000, lanes with random 1..20 cycle latency -> done=1, is_prime=0, orig_val=1000, prime_val=1009, overflow=0.
- test_number=1164 after the previous run, start pulsed from DONE -> orig_val=1164, prime_val=1171, is_prime=0; count passes 1165..1170.
- test_number=997 -> is_prime=1, prime_val=997; divisors 2..31 issued exactly once each, with at most one lane_start per cycle.
- test_number=0, 1, 2, 3 -> prime_val=2, 2, 2, 3 respectively. is_prime=1 only for 2 and 3. No lane_start for any of these.
- WIDTH=8, test_number=252 -> candidates 252..255 all composite, so overflow=1, done=1, is_prime=0.
- rst asserted mid-DISPATCH for 1000, with lanes still returning done -> all outputs 0, state=IDLE, no lane_start issued. A fresh start then gives prime_val=1009.

Source files
------------

// File: rtl/prime_pkg.sv
// prime_pkg: state encoding, default sizes and lowest-set-bit picker shared by the lane scheduler
package prime_pkg;
  localparam int DEF_NUM_LANES = 8;
  localparam int DEF_WIDTH = 32;
  localparam int MAX_LANES = 16;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    DISPATCH = 3'd2,
    DRAIN    = 3'd3,
    NEXT     = 3'd4,
    DONE     = 3'd5
  } state_t;
  function automatic logic [MAX_LANES-1:0] lowest_set(input logic [MAX_LANES-1:0] v);
    return v & (~v + MAX_LANES'(1));
  endfunction
endpackage

// File: rtl/prime_lane_alloc.sv
// prime_lane_alloc: one-hot grant of the lowest-index idle lane plus a valid flag
module prime_lane_alloc
  import prime_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES
) (
  input  logic [NUM_LANES-1:0] busy,
  output logic [NUM_LANES-1:0] grant,
  output logic                 valid
);
  logic [NUM_LANES-1:0] idle;
  logic [MAX_LANES-1:0] pick;
  assign idle  = ~busy;
  assign pick  = lowest_set(MAX_LANES'(idle));
  assign grant = pick[NUM_LANES-1:0];
  assign valid = |idle;
endmodule

// File: rtl/prime_lane_scheduler.sv
// prime_lane_scheduler: issues trial divisors to variable-latency lanes and walks candidates up to the first prime
module prime_lane_scheduler
  import prime_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int WIDTH     = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           test_number,
  output logic [NUM_LANES-1:0]       lane_start,
  output logic [WIDTH-1:0]           lane_dividend,
  output logic [NUM_LANES*WIDTH-1:0] lane_divisor,
  input  logic [NUM_LANES-1:0]       lane_done,
  input  logic [NUM_LANES-1:0]       lane_divisible,
  output logic                       busy,
  output logic                       done,
  output logic                       is_prime,
  output logic [WIDTH-1:0]           orig_val,
  output logic [WIDTH-1:0]           prime_val,
  output logic [WIDTH-1:0]           count,
  output logic                       overflow,
  output logic [2:0]                 state
);
  localparam int SW = 2 * WIDTH;
  state_t st, st_n;
  logic [NUM_LANES-1:0] lane_busy, grant, busy_left;
  logic [WIDTH-1:0] d;
  logic [SW-1:0] sq, cnt_ext;
  logic found, found_now, free, issue, accept;
  prime_lane_alloc #(.NUM_LANES(NUM_LANES)) u_alloc (
    .busy (lane_busy),
    .grant(grant),
    .valid(free)
  );
  assign cnt_ext       = {{WIDTH{1'b0}}, count};
  assign busy_left     = lane_busy & ~lane_done;
  assign found_now     = found | |(lane_busy & lane_done & lane_divisible);
  assign issue         = st == DISPATCH && sq <= cnt_ext && !found && free;
  assign accept        = (st == IDLE || st == DONE) && start;
  assign lane_dividend = count;
  assign busy          = st != IDLE && st != DONE;
  assign state         = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    case (st)
      IDLE, DONE: st_n = start ? LOAD : st;
      LOAD:       st_n = DISPATCH;
      DISPATCH:   st_n = (found || sq > cnt_ext) ? DRAIN : DISPATCH;
      DRAIN:      st_n = busy_left != '0 ? DRAIN : found_now ? NEXT : DONE;
      NEXT:       st_n = &count ? DONE : DISPATCH;
      default:    st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_start   <= '0;
      lane_busy    <= '0;
      lane_divisor <= '0;
      found        <= 1'b0;
      d            <= '0;
      sq           <= '0;
      done         <= 1'b0;
      is_prime     <= 1'b0;
      orig_val     <= '0;
      prime_val    <= '0;
      count        <= '0;
      overflow     <= 1'b0;
    end else begin
      lane_start <= issue ? grant : '0;
      lane_busy  <= busy_left | (issue ? grant : '0);
      found      <= found_now;
      if (issue) begin
        d  <= d + WIDTH'(1);
        sq <= sq + {{(WIDTH-1){1'b0}}, d, 1'b1};
      end
      for (int i = 0; i < NUM_LANES; i++)
        if (issue && grant[i]) lane_divisor[i*WIDTH +: WIDTH] <= d;
      if (accept) begin
        orig_val <= test_number;
        count    <= test_number;
        done     <= 1'b0;
        overflow <= 1'b0;
      end
      if (st == LOAD) begin
        if (count < WIDTH'(2)) count <= WIDTH'(2);
        d     <= WIDTH'(2);
        sq    <= SW'(4);
        found <= 1'b0;
      end
      if (st == DRAIN && busy_left == '0 && !found_now) begin
        done      <= 1'b1;
        prime_val <= count;
        is_prime  <= count == orig_val;
      end
      if (st == NEXT) begin
        if (&count) begin
          overflow  <= 1'b1;
          is_prime  <= 1'b0;
          prime_val <= '0;
          done      <= 1'b1;
        end else begin
          count <= count + WIDTH'(1);
          found <= 1'b0;
          d     <= WIDTH'(2);
          sq    <= SW'(4);
        end
      end
    end
  end
endmodule

// File: tb/tb_prime_lane_scheduler.sv
// tb_prime_lane_scheduler: directed vectors and corner sequences against behavioural divisibility lanes
module tb_prime_lane_scheduler;
  localparam int N = 8, W = 32, NB = 4, WB = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic a_go = 1'b0;
  logic [W-1:0] a_tn = '0;
  logic [N-1:0] a_start, a_ldone, a_ldiv;
  logic [W-1:0] a_dividend, a_orig, a_prime, a_count;
  logic [N*W-1:0] a_divisor;
  logic a_busy, a_doneo, a_isp, a_ovf;
  logic [2:0] a_state;
  prime_lane_scheduler #(.NUM_LANES(N), .WIDTH(W)) dut_a (
    .clk(clk), .rst(rst), .start(a_go), .test_number(a_tn),
    .lane_start(a_start), .lane_dividend(a_dividend), .lane_divisor(a_divisor),
    .lane_done(a_ldone), .lane_divisible(a_ldiv),
    .busy(a_busy), .done(a_doneo), .is_prime(a_isp), .orig_val(a_orig),
    .prime_val(a_prime), .count(a_count), .overflow(a_ovf), .state(a_state)
  );
  logic b_go = 1'b0;
  logic [WB-1:0] b_tn = '0;
  logic [NB-1:0] b_start, b_ldone, b_ldiv;
  logic [WB-1:0] b_dividend, b_orig, b_prime, b_count;
  logic [NB*WB-1:0] b_divisor;
  logic b_busy, b_doneo, b_isp, b_ovf;
  logic [2:0] b_state;
  prime_lane_scheduler #(.NUM_LANES(NB), .WIDTH(WB)) dut_b (
    .clk(clk), .rst(rst), .start(b_go), .test_number(b_tn),
    .lane_start(b_start), .lane_dividend(b_dividend), .lane_divisor(b_divisor),
    .lane_done(b_ldone), .lane_divisible(b_ldiv),
    .busy(b_busy), .done(b_doneo), .is_prime(b_isp), .orig_val(b_orig),
    .prime_val(b_prime), .count(b_count), .overflow(b_ovf), .state(b_state)
  );
  int lat_max = 20;
  int a_cnt [N];
  logic [W-1:0] a_dd [N], a_dv [N];
  always @(posedge clk)
    for (int i = 0; i < N; i++) begin
      a_ldone[i] <= 1'b0;
      a_ldiv[i]  <= 1'b0;
      if (a_start[i]) begin
        a_cnt[i] <= $urandom_range(lat_max, 1);
        a_dd[i]  <= a_dividend;
        a_dv[i]  <= a_divisor[i*W +: W];
      end else if (a_cnt[i] > 0) begin
        if (a_cnt[i] == 1) begin
          a_ldone[i] <= 1'b1;
          a_ldiv[i]  <= (a_dd[i] % a_dv[i]) == 0;
        end
        a_cnt[i] <= a_cnt[i] - 1;
      end
    end
  int b_cnt [NB];
  logic [WB-1:0] b_dd [NB], b_dv [NB];
  always @(posedge clk)
    for (int i = 0; i < NB; i++) begin
      b_ldone[i] <= 1'b0;
      b_ldiv[i]  <= 1'b0;
      if (b_start[i]) begin
        b_cnt[i] <= $urandom_range(lat_max, 1);
        b_dd[i]  <= b_dividend;
        b_dv[i]  <= b_divisor[i*WB +: WB];
      end else if (b_cnt[i] > 0) begin
        if (b_cnt[i] == 1) begin
          b_ldone[i] <= 1'b1;
          b_ldiv[i]  <= (b_dd[i] % b_dv[i]) == 0;
        end
        b_cnt[i] <= b_cnt[i] - 1;
      end
    end
  int issued [64];
  int starts_total = 0, multi_cycles = 0;
  logic [W-1:0] cand_q [$];
  logic [W-1:0] last_cnt = '0;
  always @(posedge clk) begin
    if ($countones(a_start) > 1) multi_cycles++;
    for (int i = 0; i < N; i++)
      if (a_start[i]) begin
        starts_total++;
        if (a_divisor[i*W +: W] < 64) issued[a_divisor[i*W +: 6]]++;
      end
    if (a_state == 3'd2 && a_count != last_cnt) begin
      cand_q.push_back(a_count);
      last_cnt = a_count;
    end
  end
  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_a(input logic [W-1:0] tn);
    @(negedge clk);
    a_tn = tn;
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    a_tn = $urandom;
    for (int c = 0; c < 30000 && !a_doneo; c++) @(negedge clk);
    check("a done reached", a_doneo, 1);
  endtask
  task automatic run_b(input logic [WB-1:0] tn);
    @(negedge clk);
    b_tn = tn;
    b_go = 1'b1;
    @(negedge clk);
    b_go = 1'b0;
    b_tn = WB'($urandom);
    for (int c = 0; c < 30000 && !b_doneo; c++) @(negedge clk);
    check("b done reached", b_doneo, 1);
  endtask
  task automatic check_a_zero(input string tag);
    check({tag, " state"}, a_state, 0);
    check({tag, " outputs"}, {a_busy, a_doneo, a_isp, a_ovf, |a_start, |a_divisor}, 0);
    check({tag, " values"}, {a_orig, a_prime}, 0);
    check({tag, " count"}, a_count, 0);
  endtask
  typedef struct {
    logic [W-1:0] tn;
    logic [W-1:0] pv;
    logic         ip;
    int           lat;
  } vec_t;
  vec_t vecs [10];
  int s0, m0, q0, bad;
  int iss0 [64];
  initial begin
    vecs[0] = '{1000, 1009, 1'b0, 20};
    vecs[1] = '{1164, 1171, 1'b0, 20};
    vecs[2] = '{997, 997, 1'b1, 20};
    vecs[3] = '{0, 2, 1'b0, 20};
    vecs[4] = '{1, 2, 1'b0, 20};
    vecs[5] = '{2, 2, 1'b1, 20};
    vecs[6] = '{3, 3, 1'b1, 20};
    vecs[7] = '{24, 29, 1'b0, 3};
    vecs[8] = '{89, 89, 1'b1, 1};
    vecs[9] = '{7919, 7919, 1'b1, 1};
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset b", {b_state, b_doneo, b_ovf, b_count}, 0);
    rst = 1'b0;
    for (int v = 0; v < 10; v++) begin
      lat_max = vecs[v].lat;
      s0 = starts_total;
      m0 = multi_cycles;
      q0 = cand_q.size();
      for (int k = 0; k < 64; k++) iss0[k] = issued[k];
      run_a(vecs[v].tn);
      check($sformatf("orig %0d", vecs[v].tn), a_orig, vecs[v].tn);
      check($sformatf("prime %0d", vecs[v].tn), a_prime, vecs[v].pv);
      check($sformatf("is_prime %0d", vecs[v].tn), a_isp, vecs[v].ip);
      check($sformatf("overflow %0d", vecs[v].tn), a_ovf, 0);
      check($sformatf("count %0d", vecs[v].tn), a_count, vecs[v].pv);
      check($sformatf("idle flags %0d", vecs[v].tn), {a_busy, a_state}, 4'd5);
      check($sformatf("one start per cycle %0d", vecs[v].tn), multi_cycles - m0, 0);
      if (vecs[v].tn <= 3) check($sformatf("no issue %0d", vecs[v].tn), starts_total - s0, 0);
      if (vecs[v].tn == 997) begin
        bad = 0;
        for (int k = 0; k < 64; k++) if (issued[k] - iss0[k] != ((k >= 2 && k <= 31) ? 1 : 0)) bad++;
        check("997 divisors 2..31 once", bad, 0);
        check("997 issue total", starts_total - s0, 30);
      end
      if (vecs[v].tn == 1164) begin
        check("1164 candidate steps", cand_q.size() - q0, 8);
        bad = 0;
        for (int k = 0; k < 8 && q0 + k < cand_q.size(); k++) if (cand_q[q0 + k] != 1164 + k) bad++;
        check("1164 candidate sequence", bad, 0);
      end
    end
    lat_max = 20;
    run_b(252);
    check("b252 overflow", b_ovf, 1);
    check("b252 is_prime", b_isp, 0);
    check("b252 prime_val", b_prime, 0);
    check("b252 orig", b_orig, 252);
    run_b(200);
    check("b200 overflow", b_ovf, 0);
    check("b200 prime_val", b_prime, 211);
    lat_max = 20;
    s0 = starts_total;
    @(negedge clk);
    a_tn = 1000;
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    for (int c = 0; c < 200 && starts_total - s0 < 2; c++) @(negedge clk);
    check("mid-run busy", a_busy, 1);
    rst = 1'b1;
    #1;
    check_a_zero("async reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = starts_total;
    repeat (40) @(negedge clk);
    check("no issue after reset", starts_total - s0, 0);
    check_a_zero("after reset idle");
    @(negedge clk);
    a_tn = 1000;
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    repeat (10) @(negedge clk);
    a_tn = 5;
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    for (int c = 0; c < 30000 && !a_doneo; c++) @(negedge clk);
    check("rerun done", a_doneo, 1);
    check("rerun orig", a_orig, 1000);
    check("rerun prime", a_prime, 1009);
    check("rerun is_prime", a_isp, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
